ps2_scan_rx: RTL

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

---
 rtl/ps2_scan_rx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronised frame capture into a scancode FIFO (parity via PS2_PARITY_CHECK_EN).
// Latency: byte at FIFO head (out_valid) 2 clk after the stop-bit sample; no empty-FIFO bypass.
// Backpressure: out_valid/out_ready pop; a good frame arriving at a full FIFO with no pop is dropped, sets sticky overflow.
module ps2_scan_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic       frame_err,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] IDLE_ONE  = TW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
`ifdef PS2_PARITY_CHECK_EN
    localparam int SW = 10;
`else
    localparam int SW = 9;
`endif
    localparam logic [3:0] SW_BITS = 4'(SW);

    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic          fall_vld;
    logic [3:0]    bit_cnt;
    logic [SW-1:0] shreg;
    logic [TW-1:0] idle_cnt;
    logic          idle_expired;
    logic          stop_vld;
    logic          frame_ok;
    logic          acc_vld;
    logic [7:0]    acc_dat;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_full, pop_vld, push_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall_vld     = clk_prev & ~clk_s2;
    assign busy         = (bit_cnt != 4'd0);
    assign stop_vld     = fall_vld && (bit_cnt == 4'd10);
    assign idle_expired = busy && !fall_vld && (idle_cnt == IDLE_LAST);

    // shreg[0] = start, shreg[8:1] = data LSB first, shreg[9] = parity when checked
`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = ~shreg[0] & dat_s2 & (^shreg[9:1]);
`else
    assign frame_ok = ~shreg[0] & dat_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 4'd0;
            shreg     <= '0;
            idle_cnt  <= '0;
            acc_vld   <= 1'b0;
            acc_dat   <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            acc_vld   <= stop_vld && frame_ok;
            frame_err <= stop_vld && !frame_ok;
            if (stop_vld && frame_ok)
                acc_dat <= shreg[8:1];
            if (fall_vld) begin
                idle_cnt <= '0;
                bit_cnt  <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
                if (bit_cnt < SW_BITS)
                    shreg <= {dat_s2, shreg[SW-1:1]};
            end else if (idle_expired) begin
                idle_cnt <= '0;
                bit_cnt  <= 4'd0;
            end else if (busy) begin
                idle_cnt <= idle_cnt + IDLE_ONE;
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    assign out_valid = (wr_ptr != rd_ptr);
    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_vld   = out_valid && out_ready;
    // a full FIFO still takes the byte when the head leaves in the same cycle
    assign push_vld  = acc_vld && (!fifo_full || pop_vld);
    assign out_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_vld)
            mem[wr_ptr[AW-1:0]] <= acc_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_vld)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_vld)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (acc_vld && fifo_full && !pop_vld)
                overflow <= 1'b1;
        end
    end
endmodule
